// File: rtl/obi_to_vx_dcache_bridge.sv
// OBI slave port to a single Vortex dcache request/response lane.
// Reads are tracked in a small reorder buffer so OBI sees responses in order;
// writes get no Vortex response and are completed locally on grant.
module obi_to_vx_dcache_bridge #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned TAG_WIDTH_BIT   = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // OBI slave
  input  logic                       obi_req_i,
  output logic                       obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]      obi_addr_i,
  input  logic                       obi_we_i,
  input  logic [DATA_WIDTH/8-1:0]    obi_be_i,
  input  logic [DATA_WIDTH-1:0]      obi_wdata_i,
  output logic                       obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]      obi_rdata_o,
  // Vortex dcache request lane
  output logic                       vx_req_valid_o,
  output logic                       vx_req_rw_o,
  output logic [DATA_WIDTH/8-1:0]    vx_req_byteen_o,
  output logic [ADDR_WIDTH-3:0]      vx_req_addr_o,
  output logic [DATA_WIDTH-1:0]      vx_req_data_o,
  output logic [TAG_WIDTH_BIT-1:0]   vx_req_tag_o,
  input  logic                       vx_req_ready_i,
  // Vortex dcache response lane
  input  logic                       vx_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]      vx_rsp_data_i,
  input  logic [TAG_WIDTH_BIT-1:0]   vx_rsp_tag_i,
  output logic                       vx_rsp_ready_o,
  output logic                       err_o
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Reorder slots
  logic [MAX_OUTSTANDING-1:0]                 valid_q, valid_d;
  logic [MAX_OUTSTANDING-1:0]                 done_q, done_d;
  logic [MAX_OUTSTANDING-1:0]                 is_write_q, is_write_d;
  logic [MAX_OUTSTANDING-1:0][DATA_WIDTH-1:0] data_q, data_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             full;
  logic             grant;
  logic             retire;
  logic             rsp_in_range;
  logic [PTR_W-1:0] rsp_idx;
  logic             rsp_accept;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^obi_addr_i[1:0];

  // Full comes from the registered count only, so a retire cannot open the
  // door for a grant in the same cycle.
  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));

  // Request path is a straight combinational pass-through
  assign vx_req_valid_o  = obi_req_i & ~full & ~rst_i;
  assign vx_req_rw_o     = obi_we_i;
  assign vx_req_byteen_o = obi_be_i;
  assign vx_req_addr_o   = obi_addr_i[ADDR_WIDTH-1:2];
  assign vx_req_data_o   = obi_wdata_i;
  assign vx_req_tag_o    = TAG_WIDTH_BIT'(wr_ptr_q);
  assign obi_gnt_o       = vx_req_valid_o & vx_req_ready_i;
  assign grant           = obi_gnt_o;

  // Every request owns a slot, so responses can always be sunk
  assign vx_rsp_ready_o = 1'b1;

  // Tags wider than the slot index must have zero upper bits to be in range
  if (TAG_WIDTH_BIT > PTR_W) begin : g_tag_hi
    assign rsp_in_range = ~|vx_rsp_tag_i[TAG_WIDTH_BIT-1:PTR_W];
  end else begin : g_tag_exact
    assign rsp_in_range = 1'b1;
  end

  assign rsp_idx    = vx_rsp_tag_i[PTR_W-1:0];
  assign rsp_accept = vx_rsp_valid_i & rsp_in_range & valid_q[rsp_idx] &
                      ~done_q[rsp_idx] & ~is_write_q[rsp_idx];

  // In-order retire from the head slot; one pulse per transaction
  assign retire       = valid_q[rd_ptr_q] & done_q[rd_ptr_q] & ~rst_i;
  assign obi_rvalid_o = retire;
  assign obi_rdata_o  = retire ? data_q[rd_ptr_q] : '0;
  assign err_o        = err_q;

  // Next-state for slots, pointers, count and error flag.
  // Retire, grant and response never touch the same slot in one cycle:
  // grant and retire share a slot only when full (grant blocked), and a
  // response only lands on a slot that is not yet done.
  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    is_write_d = is_write_q;
    data_d     = data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_d      = err_q;

    if (retire) begin
      valid_d[rd_ptr_q]    = 1'b0;
      done_d[rd_ptr_q]     = 1'b0;
      is_write_d[rd_ptr_q] = 1'b0;
      data_d[rd_ptr_q]     = '0;
      rd_ptr_d             = rd_ptr_q + 1'b1;
    end

    if (grant) begin
      valid_d[wr_ptr_q]    = 1'b1;
      is_write_d[wr_ptr_q] = obi_we_i;
      done_d[wr_ptr_q]     = obi_we_i;
      data_d[wr_ptr_q]     = '0;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end

    if (vx_rsp_valid_i) begin
      if (rsp_accept) begin
        done_d[rsp_idx] = 1'b1;
        data_d[rsp_idx] = vx_rsp_data_i;
      end else begin
        err_d = 1'b1;
      end
    end

    if (grant && !retire) begin
      count_d = count_q + 1'b1;
    end else if (retire && !grant) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers with synchronous reset; in-flight work is dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      done_q     <= '0;
      is_write_q <= '0;
      data_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      done_q     <= done_d;
      is_write_q <= is_write_d;
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_obi_to_vx_dcache_bridge.sv
// Directed bench for obi_to_vx_dcache_bridge with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_obi_to_vx_dcache_bridge;

  logic        clk;
  logic        rst;
  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic        obi_rvalid;
  logic [31:0] obi_rdata;
  logic        vx_req_valid;
  logic        vx_req_rw;
  logic [3:0]  vx_req_byteen;
  logic [29:0] vx_req_addr;
  logic [31:0] vx_req_data;
  logic [7:0]  vx_req_tag;
  logic        vx_req_ready;
  logic        vx_rsp_valid;
  logic [31:0] vx_rsp_data;
  logic [7:0]  vx_rsp_tag;
  logic        vx_rsp_ready;
  logic        err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  obi_to_vx_dcache_bridge #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .TAG_WIDTH_BIT   (8),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .obi_req_i       (obi_req),
    .obi_gnt_o       (obi_gnt),
    .obi_addr_i      (obi_addr),
    .obi_we_i        (obi_we),
    .obi_be_i        (obi_be),
    .obi_wdata_i     (obi_wdata),
    .obi_rvalid_o    (obi_rvalid),
    .obi_rdata_o     (obi_rdata),
    .vx_req_valid_o  (vx_req_valid),
    .vx_req_rw_o     (vx_req_rw),
    .vx_req_byteen_o (vx_req_byteen),
    .vx_req_addr_o   (vx_req_addr),
    .vx_req_data_o   (vx_req_data),
    .vx_req_tag_o    (vx_req_tag),
    .vx_req_ready_i  (vx_req_ready),
    .vx_rsp_valid_i  (vx_rsp_valid),
    .vx_rsp_data_i   (vx_rsp_data),
    .vx_rsp_tag_i    (vx_rsp_tag),
    .vx_rsp_ready_o  (vx_rsp_ready),
    .err_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start a new cycle: inputs may be driven after this returns
  task automatic next_cycle;
    @(negedge clk);
  endtask

  task automatic obi_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
    obi_req   = req;
    obi_we    = we;
    obi_addr  = addr;
    obi_be    = be;
    obi_wdata = wd;
  endtask

  task automatic rsp_drive(input logic v, input logic [7:0] tag, input logic [31:0] d);
    vx_rsp_valid = v;
    vx_rsp_tag   = tag;
    vx_rsp_data  = d;
  endtask

  task automatic idle;
    obi_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rsp_drive(1'b0, 8'h0, 32'h0);
    vx_req_ready = 1'b1;
  endtask

  task automatic check_rsp(input string tag, input logic rv, input logic [31:0] rd);
    check_eq({tag, "_rvalid"}, {63'd0, obi_rvalid}, {63'd0, rv});
    check_eq({tag, "_rdata"}, {32'd0, obi_rdata}, {32'd0, rd});
  endtask

  task automatic check_grant(input string tag, input logic g, input logic [7:0] t);
    check_eq({tag, "_gnt"}, {63'd0, obi_gnt}, {63'd0, g});
    check_eq({tag, "_tag"}, {56'd0, vx_req_tag}, {56'd0, t});
  endtask

  // One-cycle reset pulse with idle inputs
  task automatic pulse_reset;
    next_cycle();
    idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // Reset: request is ignored while rst is high
    next_cycle();
    obi_drive(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    #1;
    check_eq("rst_gnt", {63'd0, obi_gnt}, 64'd0);
    check_eq("rst_vx_valid", {63'd0, vx_req_valid}, 64'd0);
    check_rsp("rst", 1'b0, 32'h0);
    next_cycle();
    rst = 1'b0;
    idle();
    #1;
    check_eq("post_rst_err", {63'd0, err}, 64'd0);
    check_eq("rsp_ready", {63'd0, vx_rsp_ready}, 64'd1);
    check_rsp("post_rst", 1'b0, 32'h0);

    // Single read at 0x104
    next_cycle();
    obi_drive(1'b1, 1'b0, 32'h0000_0104, 4'hF, 32'h0);
    #1;
    check_eq("rd_vx_valid", {63'd0, vx_req_valid}, 64'd1);
    check_eq("rd_addr", {34'd0, vx_req_addr}, 64'h41);
    check_eq("rd_rw", {63'd0, vx_req_rw}, 64'd0);
    check_grant("rd", 1'b1, 8'd0);
    next_cycle();
    idle();
    #1;
    check_rsp("rd_wait", 1'b0, 32'h0);
    next_cycle();
    rsp_drive(1'b1, 8'd0, 32'hDEAD_BEEF);
    #1;
    check_rsp("rd_rsp_cycle", 1'b0, 32'h0);
    next_cycle();
    idle();
    #1;
    check_rsp("rd_retire", 1'b1, 32'hDEAD_BEEF);
    next_cycle();
    #1;
    check_rsp("rd_after", 1'b0, 32'h0);

    // Single write at 0x10 (tag 1 since the pointer moved on)
    next_cycle();
    obi_drive(1'b1, 1'b1, 32'h10, 4'b0011, 32'h1234);
    #1;
    check_eq("wr_rw", {63'd0, vx_req_rw}, 64'd1);
    check_eq("wr_be", {60'd0, vx_req_byteen}, 64'h3);
    check_eq("wr_data", {32'd0, vx_req_data}, 64'h1234);
    check_eq("wr_addr", {34'd0, vx_req_addr}, 64'h4);
    check_grant("wr", 1'b1, 8'd1);
    check_rsp("wr_same", 1'b0, 32'h0);
    next_cycle();
    idle();
    #1;
    check_rsp("wr_done", 1'b1, 32'h0);
    next_cycle();
    #1;
    check_rsp("wr_after", 1'b0, 32'h0);

    // Four reads, out-of-order responses, full backpressure
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      obi_drive(1'b1, 1'b0, 32'h200 + 32'(i) * 4, 4'hF, 32'h0);
      #1;
      check_grant($sformatf("q%0d", i), 1'b1, 8'(i));
      next_cycle();
    end
    obi_drive(1'b1, 1'b1, 32'h500, 4'hF, 32'hCAFE);
    #1;
    check_eq("full_vx_valid", {63'd0, vx_req_valid}, 64'd0);
    check_eq("full_gnt", {63'd0, obi_gnt}, 64'd0);
    next_cycle();
    rsp_drive(1'b1, 8'd2, 32'hA2);
    #1;
    check_rsp("ooo_r2", 1'b0, 32'h0);
    check_eq("ooo_r2_gnt", {63'd0, obi_gnt}, 64'd0);
    next_cycle();
    rsp_drive(1'b1, 8'd0, 32'hA0);
    #1;
    check_rsp("ooo_r0", 1'b0, 32'h0);
    next_cycle();
    rsp_drive(1'b1, 8'd3, 32'hA3);
    #1;
    check_rsp("ooo_ret0", 1'b1, 32'hA0);
    check_eq("retire_cycle_gnt", {63'd0, obi_gnt}, 64'd0);
    next_cycle();
    rsp_drive(1'b1, 8'd1, 32'hA1);
    #1;
    check_rsp("ooo_hold1", 1'b0, 32'h0);
    check_grant("after_full", 1'b1, 8'd0);
    next_cycle();
    idle();
    #1;
    check_rsp("ooo_ret1", 1'b1, 32'hA1);
    next_cycle();
    #1;
    check_rsp("ooo_ret2", 1'b1, 32'hA2);
    next_cycle();
    #1;
    check_rsp("ooo_ret3", 1'b1, 32'hA3);
    next_cycle();
    #1;
    check_rsp("ooo_wr", 1'b1, 32'h0);
    next_cycle();
    #1;
    check_rsp("ooo_end", 1'b0, 32'h0);

    // Vortex ready low for three cycles
    pulse_reset();
    vx_req_ready = 1'b0;
    obi_drive(1'b1, 1'b0, 32'h300, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("bp%0d_valid", i), {63'd0, vx_req_valid}, 64'd1);
      check_eq($sformatf("bp%0d_gnt", i), {63'd0, obi_gnt}, 64'd0);
      next_cycle();
    end
    vx_req_ready = 1'b1;
    #1;
    check_grant("bp_rel", 1'b1, 8'd0);
    next_cycle();
    idle();
    rsp_drive(1'b1, 8'd0, 32'h55);
    next_cycle();
    idle();
    #1;
    check_rsp("bp_ret", 1'b1, 32'h55);

    // R,W,W,R with read responses 5 cycles after grant; tags 1,2,3,0
    next_cycle();
    obi_drive(1'b1, 1'b0, 32'h400, 4'hF, 32'h0);
    #1;
    check_grant("mx_r1", 1'b1, 8'd1);
    next_cycle();
    obi_drive(1'b1, 1'b1, 32'h404, 4'hF, 32'h11);
    #1;
    check_grant("mx_w2", 1'b1, 8'd2);
    next_cycle();
    obi_drive(1'b1, 1'b1, 32'h408, 4'hF, 32'h22);
    #1;
    check_grant("mx_w3", 1'b1, 8'd3);
    check_rsp("mx_w2_blocked", 1'b0, 32'h0);
    next_cycle();
    obi_drive(1'b1, 1'b0, 32'h40C, 4'hF, 32'h0);
    #1;
    check_grant("mx_r0_wrap", 1'b1, 8'd0);
    check_rsp("mx_c10", 1'b0, 32'h0);
    next_cycle();
    idle();
    #1;
    check_rsp("mx_c11", 1'b0, 32'h0);
    next_cycle();
    rsp_drive(1'b1, 8'd1, 32'hB1);
    #1;
    check_rsp("mx_c12", 1'b0, 32'h0);
    next_cycle();
    idle();
    #1;
    check_rsp("mx_ret_r1", 1'b1, 32'hB1);
    next_cycle();
    #1;
    check_rsp("mx_ret_w2", 1'b1, 32'h0);
    next_cycle();
    rsp_drive(1'b1, 8'd0, 32'hB0);
    #1;
    check_rsp("mx_ret_w3", 1'b1, 32'h0);
    next_cycle();
    idle();
    #1;
    check_rsp("mx_ret_r0", 1'b1, 32'hB0);
    next_cycle();
    #1;
    check_rsp("mx_end", 1'b0, 32'h0);
    check_eq("mx_err", {63'd0, err}, 64'd0);

    // Spurious response to an empty slot
    pulse_reset();
    rsp_drive(1'b1, 8'd2, 32'h77);
    #1;
    check_eq("sp_err_same", {63'd0, err}, 64'd0);
    next_cycle();
    idle();
    #1;
    check_eq("sp_err_set", {63'd0, err}, 64'd1);
    check_rsp("sp", 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    #1;
    check_eq("sp_err_sticky", {63'd0, err}, 64'd1);

    // Reset with two reads outstanding, then a late response
    pulse_reset();
    #1;
    check_eq("rr_err_clr", {63'd0, err}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      obi_drive(1'b1, 1'b0, 32'h600 + 32'(i) * 4, 4'hF, 32'h0);
      #1;
      check_grant($sformatf("rr%0d", i), 1'b1, 8'(i));
      next_cycle();
    end
    rst = 1'b1;
    #1;
    check_eq("rr_rst_gnt", {63'd0, obi_gnt}, 64'd0);
    next_cycle();
    rst = 1'b0;
    rsp_drive(1'b1, 8'd1, 32'h99);
    obi_drive(1'b1, 1'b0, 32'h700, 4'hF, 32'h0);
    #1;
    check_grant("rr_after", 1'b1, 8'd0);
    check_rsp("rr_late", 1'b0, 32'h0);
    next_cycle();
    idle();
    #1;
    check_eq("rr_err", {63'd0, err}, 64'd1);
    check_rsp("rr_none", 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
